fsl_npi_frame_writer: RTL and testbench

- Write-direction counterpart of the background-read coprocessor.
- Accepts a 32-bit pixel stream plus address commands from the FSL slave channel, packs pixel pairs into 64-bit words and pushes them into the MPMC NPI write FIFO.
- Issues one 8-word (32-byte) NPI write request per completed burst, so composited frames can be written back to DRAM.
- Sits between the MicroBlaze/pipeline FSL link and an MPMC NPI port.

---
 rtl/fsl_npi_frame_writer_if.sv | 58 +++++
 rtl/fsl_npi_frame_writer.sv | 193 +++++++++++++++++++
 tb/tb_fsl_npi_frame_writer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsl_npi_frame_writer_if.sv
// rtl/fsl_npi_frame_writer_if.sv - FSL slave/master link and MPMC NPI port bundle for the frame writer
interface fsl_npi_frame_writer_if #(
  parameter int C_PI_ADDR_WIDTH     = 32,
  parameter int C_PI_DATA_WIDTH     = 64,
  parameter int C_PI_BE_WIDTH       = 8,
  parameter int C_PI_RDWDADDR_WIDTH = 4
);
  logic                           FSL_S_Read;
  logic [0:31]                    FSL_S_Data;
  logic                           FSL_S_Control;
  logic                           FSL_S_Exists;
  logic                           FSL_M_Write;
  logic [0:31]                    FSL_M_Data;
  logic                           FSL_M_Control;
  logic                           FSL_M_Full;
  logic                           system_dcm_locked;
  logic [C_PI_ADDR_WIDTH-1:0]     XIL_NPI_Addr;
  logic                           XIL_NPI_AddrReq;
  logic                           XIL_NPI_AddrAck;
  logic                           XIL_NPI_RNW;
  logic [3:0]                     XIL_NPI_Size;
  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_WrFIFO_Data;
  logic [C_PI_BE_WIDTH-1:0]       XIL_NPI_WrFIFO_BE;
  logic                           XIL_NPI_WrFIFO_Push;
  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_RdFIFO_Data;
  logic                           XIL_NPI_RdFIFO_Pop;
  logic [C_PI_RDWDADDR_WIDTH-1:0] XIL_NPI_RdFIFO_RdWdAddr;
  logic                           XIL_NPI_WrFIFO_AlmostFull;
  logic                           XIL_NPI_WrFIFO_Flush;
  logic                           XIL_NPI_RdFIFO_Empty;
  logic                           XIL_NPI_RdFIFO_Flush;
  logic [1:0]                     XIL_NPI_RdFIFO_Latency;
  logic                           XIL_NPI_RdModWr;
  logic                           XIL_NPI_WrFIFO_Empty;
  logic                           XIL_NPI_InitDone;

  modport master (
    output FSL_S_Read, FSL_M_Write, FSL_M_Data, FSL_M_Control,
           XIL_NPI_Addr, XIL_NPI_AddrReq, XIL_NPI_RNW, XIL_NPI_Size,
           XIL_NPI_WrFIFO_Data, XIL_NPI_WrFIFO_BE, XIL_NPI_WrFIFO_Push,
           XIL_NPI_RdFIFO_Pop, XIL_NPI_RdFIFO_Flush, XIL_NPI_WrFIFO_Flush, XIL_NPI_RdModWr,
    input  FSL_S_Data, FSL_S_Control, FSL_S_Exists, FSL_M_Full, system_dcm_locked,
           XIL_NPI_AddrAck, XIL_NPI_RdFIFO_Data, XIL_NPI_RdFIFO_RdWdAddr,
           XIL_NPI_WrFIFO_AlmostFull, XIL_NPI_RdFIFO_Empty, XIL_NPI_RdFIFO_Latency,
           XIL_NPI_WrFIFO_Empty, XIL_NPI_InitDone
  );

  modport slave (
    input  FSL_S_Read, FSL_M_Write, FSL_M_Data, FSL_M_Control,
           XIL_NPI_Addr, XIL_NPI_AddrReq, XIL_NPI_RNW, XIL_NPI_Size,
           XIL_NPI_WrFIFO_Data, XIL_NPI_WrFIFO_BE, XIL_NPI_WrFIFO_Push,
           XIL_NPI_RdFIFO_Pop, XIL_NPI_RdFIFO_Flush, XIL_NPI_WrFIFO_Flush, XIL_NPI_RdModWr,
    output FSL_S_Data, FSL_S_Control, FSL_S_Exists, FSL_M_Full, system_dcm_locked,
           XIL_NPI_AddrAck, XIL_NPI_RdFIFO_Data, XIL_NPI_RdFIFO_RdWdAddr,
           XIL_NPI_WrFIFO_AlmostFull, XIL_NPI_RdFIFO_Empty, XIL_NPI_RdFIFO_Latency,
           XIL_NPI_WrFIFO_Empty, XIL_NPI_InitDone
  );
endinterface

// File: rtl/fsl_npi_frame_writer.sv
// rtl/fsl_npi_frame_writer.sv - FSL pixel stream to MPMC NPI 8-word write bursts
// Optional status reporting on FSL master enabled by FSL_NPI_WRITER_STATUS_EN.
module fsl_npi_frame_writer #(
  parameter int C_PI_ADDR_WIDTH = 32,
  parameter int C_PI_DATA_WIDTH = 64,
  parameter int C_PI_BE_WIDTH   = 8
) (
  input logic                    FSL_Clk,
  input logic                    FSL_Rst_n,
  fsl_npi_frame_writer_if.master bus
);
  typedef enum logic [2:0] {
    WAIT_INIT,
    COLLECT,
    PAD,
`ifdef FSL_NPI_WRITER_STATUS_EN
    STATUS,
`endif
    REQ
  } state_t;

  state_t                     state, state_n;
  logic [2:0]                 wcnt;
  logic [2:0]                 wcnt_pad;
  logic [31:0]                low_q;
  logic [C_PI_DATA_WIDTH-1:0] data_q;
  logic [C_PI_BE_WIDTH-1:0]   be_q;
  logic                       push_q;
  logic [C_PI_ADDR_WIDTH-1:0] addr_q;
  logic                       pad_pending;
  logic                       addr_req;
  logic                       s_read;
  logic                       take_pixel;
  logic                       take_ctrl;
  logic                       pad_push;
  logic                       ack_take;
  logic                       status_wr;

  // The final push of a burst is still in its output register on the first REQ cycle;
  // holding the request back one cycle keeps all data ahead of the address.
  assign addr_req = (state == REQ) && !push_q;
  // A half-filled pair takes one slot to close, an empty pair takes two.
  assign wcnt_pad = wcnt + (wcnt[0] ? 3'd1 : 3'd2);

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    s_read     = 1'b0;
    take_pixel = 1'b0;
    take_ctrl  = 1'b0;
    pad_push   = 1'b0;
    ack_take   = 1'b0;
    status_wr  = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (bus.XIL_NPI_InitDone && bus.system_dcm_locked) state_n = COLLECT;
      end
      COLLECT: begin
        if (bus.FSL_S_Exists) begin
          if (bus.FSL_S_Control) begin
            if (wcnt == 3'd0) begin
              s_read    = 1'b1;
              take_ctrl = 1'b1;
`ifdef FSL_NPI_WRITER_STATUS_EN
              // A padded burst already reported on its way here.
              if (!pad_pending) state_n = STATUS;
`endif
            end else begin
              state_n = PAD;
            end
          end else if (!wcnt[0] || !bus.XIL_NPI_WrFIFO_AlmostFull) begin
            s_read     = 1'b1;
            take_pixel = 1'b1;
            if (wcnt == 3'd7) state_n = REQ;
          end
        end
      end
      PAD: begin
        if (!bus.XIL_NPI_WrFIFO_AlmostFull) begin
          pad_push = 1'b1;
          if (wcnt_pad == 3'd0) state_n = REQ;
        end
      end
      REQ: begin
        if (addr_req && bus.XIL_NPI_AddrAck) begin
          ack_take = 1'b1;
`ifdef FSL_NPI_WRITER_STATUS_EN
          state_n  = pad_pending ? STATUS : COLLECT;
`else
          state_n  = COLLECT;
`endif
        end
      end
`ifdef FSL_NPI_WRITER_STATUS_EN
      STATUS: begin
        if (!bus.FSL_M_Full) begin
          status_wr = 1'b1;
          state_n   = COLLECT;
        end
      end
`endif
      default: state_n = WAIT_INIT;
    endcase
  end

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      wcnt        <= 3'd0;
      low_q       <= 32'h0;
      data_q      <= '0;
      be_q        <= '0;
      push_q      <= 1'b0;
      addr_q      <= '0;
      pad_pending <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (take_pixel) begin
        wcnt <= wcnt + 3'd1;
        if (!wcnt[0]) begin
          low_q <= bus.FSL_S_Data;
        end else begin
          data_q <= {bus.FSL_S_Data, low_q};
          be_q   <= 8'hFF;
          push_q <= 1'b1;
        end
      end
      if (pad_push) begin
        wcnt   <= wcnt_pad;
        push_q <= 1'b1;
        data_q <= wcnt[0] ? {32'h0, low_q} : 64'h0;
        be_q   <= wcnt[0] ? 8'h0F : 8'h00;
        if (wcnt_pad == 3'd0) pad_pending <= 1'b1;
      end
      if (take_ctrl) begin
        addr_q      <= bus.FSL_S_Data & ~32'h1F;
        pad_pending <= 1'b0;
      end
      if (ack_take) addr_q <= addr_q + 32'd32;
    end
  end

`ifdef FSL_NPI_WRITER_STATUS_EN
  logic [31:0] bcnt;

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      bcnt <= 32'h0;
    end else if (status_wr) begin
      bcnt <= 32'h0;
    end else if (ack_take && bcnt != 32'hFFFF_FFFF) begin
      bcnt <= bcnt + 32'd1;
    end
  end

  assign bus.FSL_M_Write   = status_wr;
  assign bus.FSL_M_Data    = status_wr ? bcnt : 32'h0;
  assign bus.FSL_M_Control = status_wr;

  logic unused_inputs;
  assign unused_inputs = ^{bus.XIL_NPI_RdFIFO_Data, bus.XIL_NPI_RdFIFO_RdWdAddr,
                           bus.XIL_NPI_RdFIFO_Empty, bus.XIL_NPI_RdFIFO_Latency,
                           bus.XIL_NPI_WrFIFO_Empty};
`else
  assign bus.FSL_M_Write   = 1'b0;
  assign bus.FSL_M_Data    = 32'h0;
  assign bus.FSL_M_Control = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{bus.XIL_NPI_RdFIFO_Data, bus.XIL_NPI_RdFIFO_RdWdAddr,
                           bus.XIL_NPI_RdFIFO_Empty, bus.XIL_NPI_RdFIFO_Latency,
                           bus.XIL_NPI_WrFIFO_Empty, bus.FSL_M_Full, status_wr};
`endif

  assign bus.FSL_S_Read           = s_read;
  assign bus.XIL_NPI_Addr         = addr_q;
  assign bus.XIL_NPI_AddrReq      = addr_req;
  assign bus.XIL_NPI_RNW          = 1'b0;
  assign bus.XIL_NPI_Size         = 4'd2;
  assign bus.XIL_NPI_WrFIFO_Data  = data_q;
  assign bus.XIL_NPI_WrFIFO_BE    = be_q;
  assign bus.XIL_NPI_WrFIFO_Push  = push_q;
  assign bus.XIL_NPI_RdFIFO_Pop   = 1'b0;
  assign bus.XIL_NPI_RdFIFO_Flush = 1'b0;
  assign bus.XIL_NPI_WrFIFO_Flush = 1'b0;
  assign bus.XIL_NPI_RdModWr      = 1'b0;
endmodule

// File: tb/tb_fsl_npi_frame_writer.sv
// tb/tb_fsl_npi_frame_writer.sv - directed bench for fsl_npi_frame_writer
// FSL source, NPI address responder and push/status monitors run on the falling edge.
module tb_fsl_npi_frame_writer;
  logic clk;
  logic rst_n;

  fsl_npi_frame_writer_if bus ();

  fsl_npi_frame_writer dut (
    .FSL_Clk   (clk),
    .FSL_Rst_n (rst_n),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [32:0] fsl_q[$];
  logic [71:0] push_log[$];
  logic [31:0] req_addr[$];
  int          req_len[$];
  logic [32:0] status_log[$];
  int          pops = 0;
  int          ack_delay = 1;
  int          req_cnt = 0;
  logic [31:0] held_addr;
  logic        addr_moved = 1'b0;
  logic        push_in_req = 1'b0;

  initial begin
    bus.FSL_S_Exists  = 1'b0;
    bus.FSL_S_Control = 1'b0;
    bus.FSL_S_Data    = 32'h0;
    bus.XIL_NPI_AddrAck = 1'b0;
  end

  always @(negedge clk) begin
    bus.FSL_S_Exists  = (fsl_q.size() > 0);
    bus.FSL_S_Control = (fsl_q.size() > 0) ? fsl_q[0][32] : 1'b0;
    bus.FSL_S_Data    = (fsl_q.size() > 0) ? fsl_q[0][31:0] : 32'h0;
    #4;
    if (bus.FSL_S_Read) begin
      if (fsl_q.size() > 0) void'(fsl_q.pop_front());
      pops++;
    end
    if (bus.XIL_NPI_WrFIFO_Push) begin
      push_log.push_back({bus.XIL_NPI_WrFIFO_BE, bus.XIL_NPI_WrFIFO_Data});
      if (bus.XIL_NPI_AddrReq) push_in_req = 1'b1;
    end
    if (bus.FSL_M_Write) status_log.push_back({bus.FSL_M_Control, bus.FSL_M_Data});
    if (bus.XIL_NPI_AddrReq) begin
      if (req_cnt == 0) held_addr = bus.XIL_NPI_Addr;
      else if (bus.XIL_NPI_Addr !== held_addr) addr_moved = 1'b1;
      req_cnt++;
      if (req_cnt == ack_delay) begin
        bus.XIL_NPI_AddrAck = 1'b1;
        req_addr.push_back(bus.XIL_NPI_Addr);
        req_len.push_back(req_cnt);
      end else begin
        bus.XIL_NPI_AddrAck = 1'b0;
      end
    end else begin
      req_cnt = 0;
      bus.XIL_NPI_AddrAck = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_reqs(input int n);
    int k;
    k = 0;
    while (req_addr.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("req_count", 72'(req_addr.size()), 72'(n));
    cycles(3);
  endtask

  task automatic clear_logs();
    push_log.delete();
    req_addr.delete();
    req_len.delete();
  endtask

  task automatic send_pixels(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) fsl_q.push_back({1'b0, first + 32'(i)});
  endtask

  initial begin
    logic [31:0] p;
    rst_n = 1'b0;
    bus.XIL_NPI_InitDone          = 1'b0;
    bus.system_dcm_locked         = 1'b0;
    bus.FSL_M_Full                = 1'b0;
    bus.XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    bus.XIL_NPI_RdFIFO_Data       = 64'h0;
    bus.XIL_NPI_RdFIFO_RdWdAddr   = 4'h0;
    bus.XIL_NPI_RdFIFO_Empty      = 1'b1;
    bus.XIL_NPI_RdFIFO_Latency    = 2'd0;
    bus.XIL_NPI_WrFIFO_Empty      = 1'b1;
    cycles(3);
    chk("rst_s_read", 72'(bus.FSL_S_Read), 72'd0);
    chk("rst_addr_req", 72'(bus.XIL_NPI_AddrReq), 72'd0);
    chk("rst_push", 72'(bus.XIL_NPI_WrFIFO_Push), 72'd0);
    chk("rst_addr", 72'(bus.XIL_NPI_Addr), 72'd0);
    chk("rst_size", 72'(bus.XIL_NPI_Size), 72'd2);
    chk("rst_be", 72'(bus.XIL_NPI_WrFIFO_BE), 72'd0);
    chk("rst_data", 72'(bus.XIL_NPI_WrFIFO_Data), 72'd0);
    chk("rst_rnw", 72'(bus.XIL_NPI_RNW), 72'd0);
    chk("rst_m_write", 72'(bus.FSL_M_Write), 72'd0);

    // Init handshake: neither condition alone may start the block.
    rst_n = 1'b1;
    fsl_q.push_back({1'b1, 32'h1000_0013});
    bus.XIL_NPI_InitDone = 1'b1;
    cycles(5);
    bus.XIL_NPI_InitDone  = 1'b0;
    bus.system_dcm_locked = 1'b1;
    cycles(5);
    chk("no_read_before_init", 72'(pops), 72'd0);
    bus.XIL_NPI_InitDone = 1'b1;
    cycles(4);
    chk("ctrl_popped", 72'(pops), 72'd1);

    // First full burst, request acknowledged on its third cycle.
    ack_delay = 3;
    send_pixels(32'h11, 8);
    wait_reqs(1);
    chk("b1_push_count", 72'(push_log.size()), 72'd4);
    for (int i = 0; i < 4; i++) begin
      p = 32'h11 + 32'(2 * i);
      chk("b1_push", push_log[i], {8'hFF, p + 32'd1, p});
    end
    chk("b1_addr", 72'(req_addr[0]), 72'h1000_0000);
    chk("b1_req_len", 72'(req_len[0]), 72'd3);
    clear_logs();
    ack_delay = 1;
    send_pixels(32'h21, 8);
    wait_reqs(1);
    chk("b2_addr", 72'(req_addr[0]), 72'h1000_0020);
    chk("b2_push0", push_log[0], {8'hFF, 32'h22, 32'h21});

    // Control word after three pixels forces padding of the open burst.
    clear_logs();
    ack_delay = 2;
    send_pixels(32'h1, 3);
    fsl_q.push_back({1'b1, 32'h2000_0000});
    send_pixels(32'h51, 8);
    wait_reqs(2);
    chk("pad_push_count", 72'(push_log.size()), 72'd8);
    chk("pad_push0", push_log[0], {8'hFF, 32'h2, 32'h1});
    chk("pad_push1", push_log[1], {8'h0F, 32'h0, 32'h3});
    chk("pad_push2", push_log[2], {8'h00, 64'h0});
    chk("pad_push3", push_log[3], {8'h00, 64'h0});
    chk("pad_addr_old_base", 72'(req_addr[0]), 72'h1000_0040);
    chk("pad_addr_new_base", 72'(req_addr[1]), 72'h2000_0000);
    chk("pad_after_push4", push_log[4], {8'hFF, 32'h52, 32'h51});

    // Back-pressure on an odd slot blocks the pop and the push.
    clear_logs();
    ack_delay = 1;
    send_pixels(32'h31, 1);
    cycles(4);
    bus.XIL_NPI_WrFIFO_AlmostFull = 1'b1;
    pops = 0;
    send_pixels(32'h32, 15);
    cycles(6);
    chk("af_no_pop", 72'(pops), 72'd0);
    chk("af_no_push", 72'(push_log.size()), 72'd0);
    bus.XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    wait_reqs(2);
    chk("af_push_count", 72'(push_log.size()), 72'd8);
    for (int i = 0; i < 8; i++) begin
      p = 32'h31 + 32'(2 * i);
      chk("af_push", push_log[i], {8'hFF, p + 32'd1, p});
    end
    chk("af_addr0", 72'(req_addr[0]), 72'h2000_0020);
    chk("af_addr1", 72'(req_addr[1]), 72'h2000_0040);

    // Address wrap at the top of the space.
    clear_logs();
    fsl_q.push_back({1'b1, 32'hFFFF_FFE7});
    send_pixels(32'h61, 16);
    wait_reqs(2);
    chk("wrap_addr0", 72'(req_addr[0]), 72'hFFFF_FFE0);
    chk("wrap_addr1", 72'(req_addr[1]), 72'h0000_0000);
    chk("addr_stable_in_req", 72'(addr_moved), 72'd0);
    chk("no_push_during_req", 72'(push_in_req), 72'd0);

`ifdef FSL_NPI_WRITER_STATUS_EN
    fsl_q.push_back({1'b1, 32'h3000_0000});
    cycles(6);
    chk("st_prev_report", status_log[status_log.size()-1], {1'b1, 32'd2});
    status_log.delete();
    clear_logs();
    send_pixels(32'h71, 24);
    wait_reqs(3);
    bus.FSL_M_Full = 1'b1;
    fsl_q.push_back({1'b1, 32'h4000_0000});
    cycles(5);
    chk("st_held_by_full", 72'(status_log.size()), 72'd0);
    bus.FSL_M_Full = 1'b0;
    cycles(5);
    chk("st_count", 72'(status_log.size()), 72'd1);
    chk("st_word", status_log[0], {1'b1, 32'd3});
`else
    chk("st_absent_writes", 72'(status_log.size()), 72'd0);
    chk("st_absent_data", 72'(bus.FSL_M_Data), 72'd0);
`endif

    // Reset while a request is outstanding drops it without waiting for a clock.
    clear_logs();
    ack_delay = 1000;
    send_pixels(32'h81, 8);
    begin
      int k;
      k = 0;
      while (!bus.XIL_NPI_AddrReq && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("abort_req_seen", 72'(bus.XIL_NPI_AddrReq), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_drop", 72'(bus.XIL_NPI_AddrReq), 72'd0);
    chk("abort_addr", 72'(bus.XIL_NPI_Addr), 72'd0);
    fsl_q.delete();
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
